// File: rtl/mp_gen_pkg.sv
// Shared types for the memory-pattern traffic generator: FSM states, run
// modes, the data seed and a small state-classification helper.
package mp_gen_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_WR_REQ  = 3'd1,
        ST_RD_REQ  = 3'd2,
        ST_RD_WAIT = 3'd3,
        ST_DONE    = 3'd4
    } gen_state_e;

    typedef enum logic {
        MODE_BATCH      = 1'b0,
        MODE_INTERLEAVE = 1'b1
    } gen_mode_e;

    // Data pattern for index i of core c is DATA_SEED + c + i.
    localparam logic [7:0] DATA_SEED = 8'hA0;

    // True for the states in which a bus transaction is in flight.
    function automatic logic is_bus_state(input gen_state_e s);
        case (s)
            ST_WR_REQ, ST_RD_REQ, ST_RD_WAIT: return 1'b1;
            default:                          return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/seq_traffic_gen_if.sv
// Request/response bus between a traffic generator (master) and the memory
// under test (slave). Requests are held until gnt; reads return on rvalid.
interface seq_traffic_gen_if #(
    parameter int AW = 11,
    parameter int DW = 8
) ();
    logic          req;
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic          gnt;
    logic          rvalid;
    logic [DW-1:0] rdata;

    modport master (
        output req, we, addr, wdata,
        input  gnt, rvalid, rdata
    );

    modport slave (
        input  req, we, addr, wdata,
        output gnt, rvalid, rdata
    );
endinterface

// File: rtl/gen_watchdog.sv
// Wait-cycle watchdog: counts consecutive enabled cycles and flags the cycle
// that completes LIMIT of them. clear restarts the count for a new phase.
module gen_watchdog #(
    parameter int LIMIT = 255
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic expired
);
    localparam int              LIM  = (LIMIT < 1) ? 1 : LIMIT;
    localparam int              CW   = $clog2(LIM + 1);
    localparam logic [CW-1:0]   LAST = CW'(LIM - 1);

    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;

    // Next count: restart on clear, otherwise advance while waiting, stopping at LAST.
    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (enable && (count_q != LAST)) begin
            count_d = count_q + CW'(1'b1);
        end else begin
            count_d = count_q;
        end
    end

    // Count register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    // The LIMIT-th waiting cycle is the one seen while the count sits at LAST.
    assign expired = enable && !clear && (count_q == LAST);

endmodule

// File: rtl/seq_traffic_gen.sv
// Per-core memory pattern traffic generator. Writes a core-specific data
// pattern to a core-specific address window, reads it back, counts readback
// mismatches and reports pass/fail. Batch mode writes everything first;
// interleave mode does write(i), read(i) per address. Every bus phase is
// guarded by a watchdog that ends the run with timeout set.
module seq_traffic_gen
    import mp_gen_pkg::*;
#(
    parameter int            CORE_ID   = 0,
    parameter int            AW        = 11,
    parameter int            DW        = 8,
    parameter int            NUM_TXN   = 16,
    parameter logic [AW-1:0] BASE_ADDR = 11'h040,
    parameter int            STRIDE    = 1,
    parameter int            TIMEOUT   = 255
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           start,
    input  logic                           mode,
    seq_traffic_gen_if.master              bus,
    output logic                           busy,
    output logic                           done,
    output logic                           pass,
    output logic                           timeout,
    output logic [$clog2(NUM_TXN+1)-1:0]   err_count
);
    localparam int            IW        = (NUM_TXN > 1) ? $clog2(NUM_TXN) : 1;
    localparam int            EW        = $clog2(NUM_TXN + 1);
    localparam logic [IW-1:0] LAST_IDX  = IW'(NUM_TXN - 1);
    localparam logic [AW-1:0] CORE_BASE = AW'(32'(BASE_ADDR) + 32'(CORE_ID * NUM_TXN * STRIDE));
    localparam logic [AW-1:0] STRIDE_A  = AW'(STRIDE);
    localparam logic [DW-1:0] DATA_BASE = DW'(32'(DATA_SEED) + 32'(CORE_ID));

    // Address of index i inside this core's window; wraps modulo 2^AW.
    function automatic logic [AW-1:0] addr_of(input logic [IW-1:0] i);
        return CORE_BASE + (STRIDE_A * AW'(i));
    endfunction

    // Expected data pattern of index i; wraps modulo 2^DW.
    function automatic logic [DW-1:0] data_of(input logic [IW-1:0] i);
        return DATA_BASE + DW'(i);
    endfunction

    gen_state_e    state_q,   state_d;
    gen_mode_e     mode_q,    mode_d;
    logic [IW-1:0] idx_q,     idx_d;
    logic [EW-1:0] err_q,     err_d;
    logic          timeout_q, timeout_d;

    logic          req_q;
    logic          we_q;
    logic [AW-1:0] addr_q;
    logic [DW-1:0] wdata_q;
    logic          busy_q;
    logic          done_q;
    logic          pass_q;

    logic          wait_s;
    logic          read_done_s;
    logic          expired_s;

    // Phase qualifiers: are we stalled on the bus, and did a read response land this cycle.
    always_comb begin
        wait_s      = 1'b0;
        read_done_s = 1'b0;
        case (state_q)
            ST_WR_REQ: begin
                wait_s = !bus.gnt;
            end
            ST_RD_REQ: begin
                wait_s      = !bus.gnt;
                read_done_s = bus.gnt && bus.rvalid;
            end
            ST_RD_WAIT: begin
                wait_s      = !bus.rvalid;
                read_done_s = bus.rvalid;
            end
            default: begin
                wait_s      = 1'b0;
                read_done_s = 1'b0;
            end
        endcase
    end

    gen_watchdog #(
        .LIMIT (TIMEOUT)
    ) u_watchdog (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (!wait_s),
        .enable  (wait_s),
        .expired (expired_s)
    );

    // Run sequencing: index/mode bookkeeping, readback compare and timeout exit.
    always_comb begin
        state_d   = state_q;
        mode_d    = mode_q;
        idx_d     = idx_q;
        err_d     = err_q;
        timeout_d = timeout_q;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_d   = ST_WR_REQ;
                    mode_d    = gen_mode_e'(mode);
                    idx_d     = '0;
                    err_d     = '0;
                    timeout_d = 1'b0;
                end else begin
                    state_d = state_q;
                end
            end
            ST_WR_REQ: begin
                if (bus.gnt) begin
                    if (mode_q == MODE_INTERLEAVE) begin
                        state_d = ST_RD_REQ;
                    end else if (idx_q == LAST_IDX) begin
                        state_d = ST_RD_REQ;
                        idx_d   = '0;
                    end else begin
                        idx_d = idx_q + IW'(1'b1);
                    end
                end else if (expired_s) begin
                    state_d   = ST_DONE;
                    timeout_d = 1'b1;
                end else begin
                    state_d = state_q;
                end
            end
            ST_RD_REQ, ST_RD_WAIT: begin
                if (read_done_s) begin
                    if ((bus.rdata != data_of(idx_q)) && (err_q != '1)) begin
                        err_d = err_q + EW'(1'b1);
                    end else begin
                        err_d = err_q;
                    end
                    if (idx_q == LAST_IDX) begin
                        state_d = ST_DONE;
                    end else begin
                        idx_d   = idx_q + IW'(1'b1);
                        state_d = (mode_q == MODE_INTERLEAVE) ? ST_WR_REQ : ST_RD_REQ;
                    end
                end else if ((state_q == ST_RD_REQ) && bus.gnt) begin
                    state_d = ST_RD_WAIT;
                end else if (expired_s) begin
                    state_d   = ST_DONE;
                    timeout_d = 1'b1;
                end else begin
                    state_d = state_q;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Run state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            mode_q    <= MODE_BATCH;
            idx_q     <= '0;
            err_q     <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            mode_q    <= mode_d;
            idx_q     <= idx_d;
            err_q     <= err_d;
            timeout_q <= timeout_d;
        end
    end

    // Registered bus request and status, decoded from the next state so they change with it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
        end else begin
            req_q   <= (state_d == ST_WR_REQ) || (state_d == ST_RD_REQ);
            we_q    <= (state_d == ST_WR_REQ);
            addr_q  <= is_bus_state(state_d) ? addr_of(idx_d) : '0;
            wdata_q <= is_bus_state(state_d) ? data_of(idx_d) : '0;
            busy_q  <= is_bus_state(state_d);
            done_q  <= (state_d == ST_DONE);
            pass_q  <= (state_d == ST_DONE) && !timeout_d && (err_d == '0);
        end
    end

    assign bus.req   = req_q;
    assign bus.we    = we_q;
    assign bus.addr  = addr_q;
    assign bus.wdata = wdata_q;

    assign busy      = busy_q;
    assign done      = done_q;
    assign pass      = pass_q;
    assign timeout   = timeout_q;
    assign err_count = err_q;

endmodule
